// File: rtl/wca_port_interface.sv
// Port interface stage: executes {addr, cmd} from the port controller against the
// host slave-FIFO bus and the selected port's data path, reporting status back.
module wca_port_interface #(
    parameter int NBITS_ADDR     = 2,
    parameter int DWIDTH         = 16,
    parameter int BURST_LEN      = 256,
    parameter int ADDR_SETUP     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CW = $clog2(BURST_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NBITS_ADDR+1:0] pif_ctrl,
    output logic [6:0]            pif_status,
    output logic [NBITS_ADDR-1:0] host_addr,
    input  logic [DWIDTH-1:0]     host_data_in,
    output logic [DWIDTH-1:0]     host_data_out,
    output logic                  host_oe,
    output logic                  host_rd,
    output logic                  host_wr,
    output logic                  host_pktend,
    input  logic                  host_empty,
    input  logic                  host_full,
    output logic [DWIDTH-1:0]     port_data_out,
    output logic                  port_we,
    input  logic [DWIDTH-1:0]     port_data_in,
    output logic                  port_re,
    output logic [CW-1:0]         xfer_count,
    output logic                  timeout
);

    localparam int SW = $clog2(ADDR_SETUP + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BURST      = CW'(BURST_LEN);
    localparam logic [SW-1:0] SETUP_LAST = SW'(ADDR_SETUP - 1);
    localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3,
        S_PKTEND = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state, state_next;

    logic [1:0]            cmd;
    logic [NBITS_ADDR-1:0] addr;
    logic [1:0]            cmd_q;
    logic [SW-1:0]         setup_cnt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         issued;
    logic [TW-1:0]         stall;
    logic                  io_busy;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2:0]            io_state;
    logic                  blocked;
    logic                  abort;
    logic                  transfer;

    // Two-entry WRITE buffer: port words land here until the host FIFO accepts them.
    logic [DWIDTH-1:0]     wbuf [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  rd_pend;

    assign cmd  = pif_ctrl[1:0];
    assign addr = pif_ctrl[NBITS_ADDR+1:2];

    assign io_state      = state;
    assign pif_status    = {fifo_full, fifo_empty, io_busy, io_state, clk};
    assign host_data_out = wbuf[rd_ptr];
    assign transfer      = host_rd | host_wr | port_re | host_pktend;

    always_comb begin
        state_next  = state;
        host_rd     = 1'b0;
        host_wr     = 1'b0;
        port_re     = 1'b0;
        host_pktend = 1'b0;
        host_oe     = 1'b0;
        blocked     = 1'b0;
        abort       = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd != 2'd0)
                    state_next = S_SETUP;
            end
            S_SETUP: begin
                if (setup_cnt == SETUP_LAST) begin
                    case (cmd_q)
                        2'd1:    state_next = S_READ;
                        2'd2:    state_next = S_WRITE;
                        default: state_next = S_PKTEND;
                    endcase
                end
            end
            S_READ: begin
                host_rd = ~host_empty & (count < BURST);
                blocked = host_empty & (count < BURST);
                // Wait for the last registered port_we to drain before finishing.
                if (count == BURST && !port_we) begin
                    state_next = S_DONE;
                end else if (blocked && stall == STALL_LAST) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_WRITE: begin
                host_oe = 1'b1;
                port_re = (issued < BURST) & ((occ + {1'b0, rd_pend}) < 2'd2);
                host_wr = (occ != 2'd0) & ~host_full;
                blocked = (occ != 2'd0) & host_full;
                if (count == BURST && occ == 2'd0 && !rd_pend) begin
                    state_next = S_DONE;
                end else if (blocked && stall == STALL_LAST) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_PKTEND: begin
                host_oe     = 1'b1;
                host_pktend = ~host_full;
                blocked     = host_full;
                if (!host_full) begin
                    state_next = S_DONE;
                end else if (stall == STALL_LAST) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Only a fresh IDLE cmd re-arms; a held cmd cannot re-trigger.
                if (cmd == 2'd0)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            io_busy       <= 1'b0;
            fifo_full     <= 1'b0;
            fifo_empty    <= 1'b0;
            timeout       <= 1'b0;
            port_we       <= 1'b0;
            port_data_out <= '0;
            rd_pend       <= 1'b0;
            host_addr     <= '0;
            cmd_q         <= 2'd0;
            setup_cnt     <= '0;
            count         <= '0;
            issued        <= '0;
            stall         <= '0;
            xfer_count    <= '0;
            wbuf[0]       <= '0;
            wbuf[1]       <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            occ           <= 2'd0;
        end else begin
            state      <= state_next;
            io_busy    <= (state_next != S_IDLE);
            fifo_full  <= host_full;
            fifo_empty <= host_empty;
            timeout    <= abort;
            port_we    <= host_rd;
            rd_pend    <= port_re;
            if (host_rd)
                port_data_out <= host_data_in;

            if (state == S_SETUP)
                setup_cnt <= setup_cnt + 1'b1;
            if ((host_rd || host_wr) && count < BURST)
                count <= count + 1'b1;
            if (port_re)
                issued <= issued + 1'b1;
            if (transfer)
                stall <= '0;
            else if (blocked)
                stall <= stall + 1'b1;

            if (state == S_IDLE && cmd != 2'd0) begin
                host_addr <= addr;
                cmd_q     <= cmd;
                setup_cnt <= '0;
                count     <= '0;
                issued    <= '0;
                stall     <= '0;
            end

            // Leaving WRITE (normally or on abort) drops whatever is still buffered.
            if (state_next != S_WRITE) begin
                occ    <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (rd_pend) begin
                    wbuf[wr_ptr] <= port_data_in;
                    wr_ptr       <= ~wr_ptr;
                end
                if (host_wr)
                    rd_ptr <= ~rd_ptr;
                occ <= occ + {1'b0, rd_pend} - {1'b0, host_wr};
            end

            if (state != S_DONE && state_next == S_DONE)
                xfer_count <= count;
        end
    end

endmodule

// File: tb/tb_wca_port_interface.sv
// Bench for wca_port_interface: randomized host/port traffic checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_wca_port_interface;

    localparam int NA = 2;
    localparam int DW = 16;
    localparam int BL = 256;
    localparam int AS = 2;
    localparam int TO = 1024;
    localparam int CW = $clog2(BL + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NA+1:0] pif_ctrl = '0;
    logic [6:0]    pif_status;
    logic [NA-1:0] host_addr;
    logic [DW-1:0] host_data_in = '0;
    logic [DW-1:0] host_data_out;
    logic          host_oe, host_rd, host_wr, host_pktend;
    logic          host_empty = 1'b1;
    logic          host_full = 1'b0;
    logic [DW-1:0] port_data_out;
    logic          port_we;
    logic [DW-1:0] port_data_in = '0;
    logic          port_re;
    logic [CW-1:0] xfer_count;
    logic          timeout;

    wca_port_interface #(
        .NBITS_ADDR(NA), .DWIDTH(DW), .BURST_LEN(BL),
        .ADDR_SETUP(AS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .pif_ctrl(pif_ctrl), .pif_status(pif_status),
        .host_addr(host_addr), .host_data_in(host_data_in), .host_data_out(host_data_out),
        .host_oe(host_oe), .host_rd(host_rd), .host_wr(host_wr), .host_pktend(host_pktend),
        .host_empty(host_empty), .host_full(host_full),
        .port_data_out(port_data_out), .port_we(port_we),
        .port_data_in(port_data_in), .port_re(port_re),
        .xfer_count(xfer_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model state: phase, counters and a queue of words owed to the host.
    int            m_st = 0, m_cmd = 0, m_addr = 0, m_setup = 0;
    int            m_cnt = 0, m_iss = 0, m_infl = 0, m_stall = 0, m_xfer = 0;
    bit            m_we = 0, m_to = 0, m_ff = 0, m_fe = 0;
    logic [DW-1:0] m_wdat = '0;
    logic [DW-1:0] wq[$];
    bit            e_rd, e_re, e_wr, e_pk, e_oe, blk, to_n;
    int            cmd_v;

    // Observed tallies and stimulus controls.
    int            cyc = 0, n_rd = 0, n_we = 0, n_wr = 0, n_re = 0, n_pkt = 0, n_to = 0, n_acc = 0;
    int            run = 0, max_run = 0, first_rd = -1, busy_cyc = -1, prev_st = 0, cmd_cyc = 0;
    bit            chk_en = 0;
    int            fmode = 0, tmode = 0, tcyc = 0, ramp = 0;
    bit            fe_fix = 1, ff_fix = 0;
    logic          re_q = 1'b0;
    logic [DW-1:0] pbase = '0;

    always @(posedge clk) re_q <= port_re;

    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            e_rd = (m_st == 2) && !host_empty && (m_cnt < BL);
            e_re = (m_st == 3) && (m_iss < BL) && (wq.size() + m_infl < 2);
            e_wr = (m_st == 3) && (wq.size() != 0) && !host_full;
            e_pk = (m_st == 4) && !host_full;
            e_oe = (m_st == 3) || (m_st == 4);

            chk("io_state", 32'(pif_status[3:1]), 32'(m_st));
            chk("io_busy", 32'(pif_status[4]), 32'(m_st != 0));
            chk("fifo_empty", 32'(pif_status[5]), 32'(m_fe));
            chk("fifo_full", 32'(pif_status[6]), 32'(m_ff));
            chk("status_clk", 32'(pif_status[0]), 32'(0));
            chk("host_rd", 32'(host_rd), 32'(e_rd));
            chk("port_we", 32'(port_we), 32'(m_we));
            chk("port_re", 32'(port_re), 32'(e_re));
            chk("host_wr", 32'(host_wr), 32'(e_wr));
            chk("host_pktend", 32'(host_pktend), 32'(e_pk));
            chk("host_oe", 32'(host_oe), 32'(e_oe));
            chk("timeout", 32'(timeout), 32'(m_to));
            chk("host_addr", 32'(host_addr), 32'(m_addr));
            chk("xfer_count", 32'(xfer_count), 32'(m_xfer));
            if (m_we) chk("port_data_out", 32'(port_data_out), 32'(m_wdat));
            if (e_wr) chk("host_data_out", 32'(host_data_out), 32'(wq[0]));
            if (tmode == 2 && host_wr) chk("wr_order", 32'(host_data_out), 32'(n_wr));

            if (host_rd === 1'b1) begin
                if (first_rd < 0) first_rd = cyc;
                n_rd++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (port_we === 1'b1) n_we++;
            if (host_wr === 1'b1) n_wr++;
            if (port_re === 1'b1) n_re++;
            if (host_pktend === 1'b1) n_pkt++;
            if (timeout === 1'b1) n_to++;
            if (pif_status[4] === 1'b1 && busy_cyc < 0) busy_cyc = cyc;
            if (prev_st == 0 && pif_status[3:1] == 3'd1) n_acc++;
            prev_st = 32'(pif_status[3:1]);
            if (tmode == 2 && pif_status[3:1] == 3'd3)
                chk("buffered_le2", 32'((n_re - n_wr) <= 2), 32'(1));

            // Advance the model across the coming edge.
            cmd_v = 32'(pif_ctrl[1:0]);
            to_n  = 0;
            if (reset) begin
                m_st = 0; m_addr = 0; m_xfer = 0; m_cnt = 0; m_iss = 0; m_infl = 0;
                m_stall = 0; m_ff = 0; m_fe = 0;
                wq.delete();
                e_rd = 0;
            end else begin
                case (m_st)
                    0: if (cmd_v != 0) begin
                        m_addr = 32'(pif_ctrl[NA+1:2]); m_cmd = cmd_v;
                        m_cnt = 0; m_iss = 0; m_stall = 0; m_setup = AS; m_st = 1;
                    end
                    1: begin
                        m_setup--;
                        if (m_setup == 0) m_st = (m_cmd == 1) ? 2 : (m_cmd == 2) ? 3 : 4;
                    end
                    2: begin
                        if (m_cnt == BL && !m_we) begin
                            m_xfer = m_cnt; m_st = 5;
                        end else if (e_rd) begin
                            m_cnt++; m_stall = 0;
                        end else if (m_cnt < BL) begin
                            m_stall++;
                            if (m_stall == TO) begin to_n = 1; m_xfer = m_cnt; m_st = 5; end
                        end
                    end
                    3: begin
                        blk = (wq.size() != 0) && host_full;
                        if (m_cnt == BL && wq.size() == 0 && m_infl == 0) begin
                            m_xfer = m_cnt; m_st = 5;
                        end else begin
                            if (e_wr) begin void'(wq.pop_front()); m_cnt++; end
                            if (m_infl != 0) wq.push_back(port_data_in);
                            m_infl = e_re ? 1 : 0;
                            if (e_re) m_iss++;
                            if (e_wr || e_re) begin
                                m_stall = 0;
                            end else if (blk) begin
                                m_stall++;
                                if (m_stall == TO) begin
                                    to_n = 1; m_xfer = m_cnt; m_st = 5;
                                    wq.delete(); m_infl = 0;
                                end
                            end
                        end
                    end
                    4: begin
                        if (e_pk) begin
                            m_xfer = m_cnt; m_st = 5; m_stall = 0;
                        end else begin
                            m_stall++;
                            if (m_stall == TO) begin to_n = 1; m_xfer = m_cnt; m_st = 5; end
                        end
                    end
                    default: if (cmd_v == 0) m_st = 0;
                endcase
                m_ff = host_full;
                m_fe = host_empty;
            end
            m_we   = e_rd;
            m_wdat = host_data_in;
            m_to   = to_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
        if (re_q === 1'b1) begin
            port_data_in = pbase + DW'(ramp);
            ramp++;
        end else begin
            port_data_in = DW'($urandom);
        end
        host_data_in = DW'($urandom);
        case (fmode)
            1: begin
                host_empty = ($urandom_range(0, 3) == 0);
                host_full  = ($urandom_range(0, 3) == 0);
            end
            2: begin host_empty = 1'b0; host_full = ((tcyc % 5) < 3); end
            3: begin host_empty = (n_rd >= 10); host_full = 1'b0; end
            default: begin host_empty = fe_fix; host_full = ff_fix; end
        endcase
        #1;
    endtask

    task automatic start_cmd(input int c, input int a);
        n_rd = 0; n_we = 0; n_wr = 0; n_re = 0; n_pkt = 0; n_to = 0; n_acc = 0;
        run = 0; max_run = 0; first_rd = -1; busy_cyc = -1; ramp = 0;
        pif_ctrl = {NA'(a), 2'(c)};
        cmd_cyc = cyc + 1;
    endtask

    task automatic wait_state(input int st, input int lim, input string nm);
        int k = 0;
        while (32'(pif_status[3:1]) != st && k < lim) begin tick(); k++; end
        chk(nm, 32'(pif_status[3:1]), 32'(st));
    endtask

    initial begin
        int k;
        tick();
        chk_en = 1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", 32'(pif_status[3:1]), 32'(0));
        chk("rst_busy", 32'(pif_status[4]), 32'(0));
        chk("rst_strobes", 32'({host_rd, host_wr, host_pktend, port_re, port_we, host_oe}), 32'(0));
        chk("rst_xfer", 32'(xfer_count), 32'(0));
        chk("rst_addr", 32'(host_addr), 32'(0));

        // Full-rate READ burst
        fe_fix = 0; ff_fix = 0;
        start_cmd(1, 2);
        tick();
        pif_ctrl = '0;
        wait_state(0, 400, "read_return_idle");
        chk("read_addr", 32'(host_addr), 32'(2));
        chk("read_first_rd_lat", 32'(first_rd - cmd_cyc), 32'(1 + AS));
        chk("read_n_rd", 32'(n_rd), 32'(256));
        chk("read_n_we", 32'(n_we), 32'(256));
        chk("read_run", 32'(max_run), 32'(256));
        chk("read_xfer", 32'(xfer_count), 32'(256));

        // WRITE ramp while host_full toggles 3 on / 2 off
        fmode = 2; tmode = 2; pbase = '0;
        start_cmd(2, 3);
        wait_state(5, 2000, "write_done");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("write_hold_busy", 32'(pif_status[4]), 32'(1));
        end
        chk("write_single_accept", 32'(n_acc), 32'(1));
        chk("write_xfer", 32'(xfer_count), 32'(256));
        chk("write_n_wr", 32'(n_wr), 32'(256));
        pif_ctrl = '0;
        tick();
        chk("write_release_state", 32'(pif_status[3:1]), 32'(0));
        tmode = 0;

        // READ that starves after 10 words and times out
        fmode = 3;
        start_cmd(1, 1);
        k = 0;
        while (n_to == 0 && k < 1500) begin tick(); k++; end
        chk("to_pulse", 32'(n_to), 32'(1));
        chk("to_xfer", 32'(xfer_count), 32'(10));
        chk("to_state", 32'(pif_status[3:1]), 32'(5));
        repeat (20) tick();
        chk("to_hold_busy", 32'(pif_status[4]), 32'(1));
        chk("to_no_more_rd", 32'(n_rd), 32'(10));
        pif_ctrl = '0;
        tick();
        chk("to_release_state", 32'(pif_status[3:1]), 32'(0));
        repeat (5) tick();
        chk("to_single_accept", 32'(n_acc), 32'(1));
        chk("to_pulse_once", 32'(n_to), 32'(1));

        // PKTEND
        fmode = 0; fe_fix = 1; ff_fix = 0;
        start_cmd(3, 1);
        tick();
        pif_ctrl = '0;
        wait_state(0, 50, "pkt_return_idle");
        chk("pkt_count", 32'(n_pkt), 32'(1));
        chk("pkt_addr", 32'(host_addr), 32'(1));
        chk("pkt_xfer", 32'(xfer_count), 32'(0));

        // Reset in the middle of a WRITE, then a normal READ
        fmode = 1; pbase = DW'($urandom);
        start_cmd(2, 2);
        tick();
        pif_ctrl = '0;
        k = 0;
        while (n_wr < 100 && k < 2000) begin tick(); k++; end
        chk("midwr_reached", 32'(n_wr), 32'(100));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midwr_strobes", 32'({host_rd, host_wr, host_pktend, port_re, port_we}), 32'(0));
        chk("midwr_state", 32'(pif_status[3:1]), 32'(0));
        chk("midwr_busy", 32'(pif_status[4]), 32'(0));
        start_cmd(1, 0);
        tick();
        pif_ctrl = '0;
        wait_state(0, 1500, "postrst_read_idle");
        chk("postrst_n_rd", 32'(n_rd), 32'(256));
        chk("postrst_xfer", 32'(xfer_count), 32'(256));

        // Controller protocol: cmd held 3 cycles
        fmode = 0; fe_fix = 0; ff_fix = 0;
        start_cmd(1, 3);
        tick();
        chk("proto_busy_next", 32'(pif_status[4]), 32'(1));
        tick();
        chk("proto_busy_lat", 32'(busy_cyc - cmd_cyc), 32'(1));
        tick();
        pif_ctrl = '0;
        wait_state(0, 400, "proto_idle");
        repeat (10) tick();
        chk("proto_single_accept", 32'(n_acc), 32'(1));
        chk("proto_n_rd", 32'(n_rd), 32'(256));

        // Random commands with random host flags
        fmode = 1;
        for (int i = 0; i < 10; i++) begin
            pbase = DW'($urandom);
            start_cmd($urandom_range(1, 3), $urandom_range(0, 3));
            repeat ($urandom_range(1, 4)) tick();
            pif_ctrl = '0;
            wait_state(0, 3000, "rand_idle");
            chk("rand_single_accept", 32'(n_acc), 32'(1));
        end

        fmode = 0;
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wca_port_interface.md
Name: wca_port_interface

Overview:
- Port interface stage directly downstream of the port controller: executes the {addr, cmd} issued on pif_ctrl against the host slave-FIFO bus and the selected port's data path, and returns pif_status.
- Moves bursts of up to BURST_LEN words host->port (READ) or port->host (WRITE), or issues a packet-end (PKTEND).
- Reports busy, state and host FIFO flags back to the controller.

Parameters:
- NBITS_ADDR, 2, width of the port/endpoint address.
- DWIDTH, 16, host and port data word width.
- BURST_LEN, 256, maximum words per READ/WRITE command.
- ADDR_SETUP, 2, cycles that host_addr must be stable before the first strobe (min 1).
- TIMEOUT_CYCLES, 1024, consecutive stalled cycles before a burst is aborted.

Ports:
- clk  in  1  interface clock; also driven combinationally onto pif_status[0].
- reset  in  1  reset, synchronous, active-high.
- pif_ctrl  in  NBITS_ADDR+2  {addr, cmd[1:0]}. cmd encoding: 0 IDLE, 1 READ, 2 WRITE, 3 PKTEND.
- pif_status  out  7  {fifo_full, fifo_empty, io_busy, io_state[2:0], clk}.
- host_addr  out  NBITS_ADDR  endpoint select, latched at command accept.
- host_data_in  in  DWIDTH  host FIFO read data, valid while host_empty=0.
- host_data_out  out  DWIDTH  host FIFO write data.
- host_oe  out  1  host data bus drive enable.
- host_rd  out  1  host FIFO pop strobe.
- host_wr  out  1  host FIFO push strobe.
- host_pktend  out  1  packet-end strobe.
- host_empty  in  1  selected endpoint empty.
- host_full  in  1  selected endpoint full.
- port_data_out  out  DWIDTH  word to the port (READ).
- port_we  out  1  port write strobe, qualifies port_data_out.
- port_data_in  in  DWIDTH  word from the port; valid exactly 1 cycle after port_re.
- port_re  out  1  port read request (WRITE).
- xfer_count  out  clog2(BURST_LEN+1)  words moved by the last command; updated on entry to DONE.
- timeout  out  1  one-cycle pulse when a burst aborts on timeout.

Behaviour:
- Reset values: all strobes, host_oe, io_busy, timeout = 0; io_state = IDLE; host_addr, xfer_count, data registers = 0. Reset mid-burst returns to IDLE at the next edge; an in-flight word is discarded.
- io_state encoding: 0 IDLE, 1 SETUP, 2 READ, 3 WRITE, 4 PKTEND, 5 DONE.
- fifo_full/fifo_empty: host_full/host_empty registered once.
- io_busy = (io_state != IDLE), registered. It asserts the cycle after a non-IDLE cmd is sampled in IDLE.
- IDLE: when cmd != 0, latch addr into host_addr, latch cmd, clear the word and stall counters, then go to SETUP.
- SETUP: hold ADDR_SETUP cycles, then go to READ, WRITE or PKTEND per the latched cmd. cmd changes after accept are ignored.
- READ:
  - Each cycle, host_rd = ~host_empty & (count < BURST_LEN).
  - On host_rd, register host_data_in into port_data_out and pulse port_we the next cycle. Latency from host_rd to port_we is 1 cycle.
  - Sustained rate is 1 word/cycle.
- WRITE:
  - Uses a 2-entry output buffer.
  - port_re = (issued < BURST_LEN) & (occupancy + in_flight < 2).
  - The returned port word enters the buffer.
  - host_wr = buffer_nonempty & ~host_full; it pushes the head word to host_data_out the same cycle.
  - host_oe = 1 throughout WRITE and PKTEND.
  - The buffer never overflows, and no word is lost or duplicated while host_full toggles.
- Completion: READ/WRITE is complete when count == BURST_LEN and the pipeline is empty, or on timeout → DONE.
- Stall: the stall counter increments on each cycle a needed strobe is blocked by a host flag, and clears on any transfer. At TIMEOUT_CYCLES it pulses timeout and goes to DONE; in WRITE, buffered words are dropped.
- PKTEND: pulse host_pktend for 1 cycle, then go to DONE. If host_full is set, wait; the wait is subject to the same timeout.
- DONE:
  - io_busy stays 1.
  - Return to IDLE on the first cycle cmd == IDLE is sampled; io_busy drops the following cycle.
  - This prevents re-trigger by a cmd still held from the previous command.
- count and xfer_count saturate at BURST_LEN; count == 0 is a legal result (host_empty for the whole burst until timeout).

Test Plan:
- Reset, then cmd=READ, addr=2, host_empty=0 → host_addr=2; first host_rd after 1+ADDR_SETUP cycles; 256 consecutive host_rd; 256 port_we each lagging host_rd by 1; xfer_count=256.
- WRITE with host_full toggling 3 cycles on / 2 off on a ramp 0..255 from port → host_wr data exactly 0..255 in order; never more than 2 buffered; io_busy held until cmd=IDLE.
- READ with host_empty after word 10, held 1024 cycles → timeout pulse; xfer_count=10; DONE; cmd held non-IDLE keeps io_busy=1; release → IDLE, no second burst.
- cmd=PKTEND, addr=1, host_full=0 → single host_pktend pulse with host_addr=1; DONE; xfer_count=0.
- Assert reset mid-WRITE at word 100 → next cycle all strobes 0, io_state=0, io_busy=0; a new READ then runs normally.
- Controller protocol: cmd held 3 cycles, then IDLE after io_busy observed → io_busy high ≤1 cycle after cmd; exactly one command executes per cmd assertion.
